// File: rtl/pred_ctrl.sv
// Sequencer for a causal-predictor frame compressor: read cur/up/left pixels, predict, write residual.
// Optional PRED_CTRL_STALL_EN adds i_mem_ready so each read holds until the memory accepts it.
module pred_ctrl #(
   parameter int IMG_W  = 512,
   parameter int IMG_H  = 512,
   parameter int ADDR_W = 18
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [1:0]        i_mode,
`ifdef PRED_CTRL_STALL_EN
   input  logic              i_mem_ready,
`endif
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic              o_load_cur,
   output logic              o_load_up,
   output logic              o_load_left,
   output logic              o_load_pred,
   output logic [2:0]        o_opcode,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic              o_first_row,
   output logic              o_first_col,
   output logic              o_busy,
   output logic              o_done
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = $clog2(IMG_H + 1);

   localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
   localparam logic [ADDR_W-1:0] LIN_LAST = ADDR_W'(IMG_W * IMG_H - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

   localparam logic [1:0] M_AVG  = 2'd0;
   localparam logic [1:0] M_LEFT = 2'd1;
   localparam logic [1:0] M_UP   = 2'd2;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_D1   = 3'b001;
   localparam logic [2:0] OP_D2   = 3'b010;
   localparam logic [2:0] OP_AVG  = 3'b100;
   localparam logic [2:0] OP_SUB2 = 3'b110;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_CUR_RD  = 4'd1,
      S_CUR_LD  = 4'd2,
      S_UP_RD   = 4'd3,
      S_UP_LD   = 4'd4,
      S_LEFT_RD = 4'd5,
      S_LEFT_LD = 4'd6,
      S_PRED    = 4'd7,
      S_RES     = 4'd8,
      S_DONE    = 4'd9
   } state_t;

   state_t            r_state;
   logic [CW-1:0]     r_col;
   logic [RW-1:0]     r_row;
   logic [ADDR_W-1:0] r_lin;
   logic [1:0]        r_mode;

   logic              r_rd_en;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_load_cur;
   logic              r_load_up;
   logic              r_load_left;
   logic              r_load_pred;
   logic [2:0]        r_opcode;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic              r_busy;
   logic              r_done;

   logic              w_accept;
   logic              w_need_up;
   logic              w_need_left;
   logic [2:0]        w_pred_op;

`ifdef PRED_CTRL_STALL_EN
   assign w_accept = i_mem_ready;
`else
   assign w_accept = 1'b1;
`endif

   // Neighbour needs depend only on the pixel position and latched mode, so they
   // stay stable for the whole pixel and also select the PRED opcode.
   assign w_need_up   = (r_row != '0) && ((r_mode == M_AVG) || (r_mode == M_UP));
   assign w_need_left = (r_col != '0) && ((r_mode == M_AVG) || (r_mode == M_LEFT));

   always_comb begin
      w_pred_op = OP_NOP;
      if (w_need_up && w_need_left) w_pred_op = OP_AVG;
      else if (w_need_up)           w_pred_op = OP_D2;
      else if (w_need_left)         w_pred_op = OP_D1;
   end

   // Outputs are registered for the state being entered, so each strobe lines up
   // with the cycle its state is occupied.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_col       <= '0;
         r_row       <= '0;
         r_lin       <= '0;
         r_mode      <= '0;
         r_rd_en     <= 1'b0;
         r_rd_addr   <= '0;
         r_load_cur  <= 1'b0;
         r_load_up   <= 1'b0;
         r_load_left <= 1'b0;
         r_load_pred <= 1'b0;
         r_opcode    <= OP_NOP;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_rd_en     <= 1'b0;
         r_rd_addr   <= '0;
         r_load_cur  <= 1'b0;
         r_load_up   <= 1'b0;
         r_load_left <= 1'b0;
         r_load_pred <= 1'b0;
         r_opcode    <= OP_NOP;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_busy      <= 1'b1;
         r_done      <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_busy <= 1'b0;
               if (i_start) begin
                  r_state   <= S_CUR_RD;
                  r_col     <= '0;
                  r_row     <= '0;
                  r_lin     <= '0;
                  r_mode    <= i_mode;
                  r_busy    <= 1'b1;
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= '0;
               end
            end

            S_CUR_RD: begin
               if (w_accept) begin
                  r_state    <= S_CUR_LD;
                  r_load_cur <= 1'b1;
               end else begin
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= r_rd_addr;
               end
            end

            S_CUR_LD: begin
               if (w_need_up) begin
                  r_state   <= S_UP_RD;
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= r_lin - ROW_STEP;
               end else if (w_need_left) begin
                  r_state   <= S_LEFT_RD;
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= r_lin - ADDR_W'(1);
               end else begin
                  r_state     <= S_PRED;
                  r_load_pred <= 1'b1;
                  r_opcode    <= w_pred_op;
               end
            end

            S_UP_RD: begin
               if (w_accept) begin
                  r_state   <= S_UP_LD;
                  r_load_up <= 1'b1;
               end else begin
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= r_rd_addr;
               end
            end

            S_UP_LD: begin
               if (w_need_left) begin
                  r_state   <= S_LEFT_RD;
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= r_lin - ADDR_W'(1);
               end else begin
                  r_state     <= S_PRED;
                  r_load_pred <= 1'b1;
                  r_opcode    <= w_pred_op;
               end
            end

            S_LEFT_RD: begin
               if (w_accept) begin
                  r_state     <= S_LEFT_LD;
                  r_load_left <= 1'b1;
               end else begin
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= r_rd_addr;
               end
            end

            S_LEFT_LD: begin
               r_state     <= S_PRED;
               r_load_pred <= 1'b1;
               r_opcode    <= w_pred_op;
            end

            S_PRED: begin
               r_state   <= S_RES;
               r_wr_en   <= 1'b1;
               r_opcode  <= OP_SUB2;
               r_wr_addr <= r_lin;
            end

            S_RES: begin
               r_lin <= r_lin + ADDR_W'(1);
               if (r_col == COL_LAST) begin
                  r_col <= '0;
                  r_row <= r_row + RW'(1);
               end else begin
                  r_col <= r_col + CW'(1);
               end
               if (r_lin == LIN_LAST) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state   <= S_CUR_RD;
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= r_lin + ADDR_W'(1);
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_rd_en     = r_rd_en;
   assign o_rd_addr   = r_rd_addr;
   assign o_load_cur  = r_load_cur;
   assign o_load_up   = r_load_up;
   assign o_load_left = r_load_left;
   assign o_load_pred = r_load_pred;
   assign o_opcode    = r_opcode;
   assign o_wr_en     = r_wr_en;
   assign o_wr_addr   = r_wr_addr;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   // Edge flags only mean something while a frame is running; forced low in IDLE.
   assign o_first_row = r_busy && (r_row == '0);
   assign o_first_col = r_busy && (r_col == '0);

endmodule
